systolic_mm_array: RTL and testbench

- Parametrised N×N output-stationary systolic matrix multiplier; next generation of the fixed 5-lane 8-bit systolic array top.
- Computes C = A·B over K streamed beats. Beat k carries column k of A and row k of B.
- Adds: ready/valid input and output handshakes, internal input skewing, signed/unsigned mode, cross-batch accumulation, and row-serial result readout with backpressure.

---
 rtl/systolic_mm_array_if.sv | 27 ++
 rtl/systolic_mm_array.sv | 215 +++++++++++++++++++++
 tb/tb_systolic_mm_array.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_mm_array_if.sv
// Beat-in / row-out handshake bundle for the systolic matrix multiplier.
// master = stimulus side, slave = array side.
interface systolic_mm_array_if #(
    parameter int N  = 5,
    parameter int DW = 8,
    parameter int AW = 20
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 acc_en;
    logic [N*DW-1:0]      a_col;
    logic [N*DW-1:0]      b_row;
    logic                 out_valid;
    logic                 out_ready;
    logic [N*AW-1:0]      out_row;
    logic [$clog2(N)-1:0] out_row_idx;
    logic                 busy;

    modport master (
        output in_valid, acc_en, a_col, b_row, out_ready,
        input  in_ready, out_valid, out_row, out_row_idx, busy
    );
    modport slave (
        input  in_valid, acc_en, a_col, b_row, out_ready,
        output in_ready, out_valid, out_row, out_row_idx, busy
    );
endinterface

// File: rtl/systolic_mm_array.sv
// N x N output-stationary systolic multiplier: streams K beats of A columns /
// B rows through skew registers into a PE grid, then reads C out row by row.
module systolic_mm_pe #(
    parameter int DW     = 8,
    parameter int AW     = 20,
    parameter int SIGNED = 1
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          zero_acc,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    output logic [DW-1:0] a_q,
    output logic [DW-1:0] b_q,
    output logic [AW-1:0] acc_q
);
    logic [DW-1:0] a_d, b_d;
    logic [AW-1:0] a_x, b_x, acc_d;

    // Extending both operands to AW keeps the product exact modulo 2^AW.
    always_comb begin
        a_d   = a_in;
        b_d   = b_in;
        a_x   = (SIGNED != 0) ? {{(AW-DW){a_q[DW-1]}}, a_q} : {{(AW-DW){1'b0}}, a_q};
        b_x   = (SIGNED != 0) ? {{(AW-DW){b_q[DW-1]}}, b_q} : {{(AW-DW){1'b0}}, b_q};
        acc_d = zero_acc ? '0 : acc_q + a_x * b_x;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end
endmodule

module systolic_mm_array #(
    parameter int N      = 5,
    parameter int DW     = 8,
    parameter int AW     = 20,
    parameter int K      = 5,
    parameter int SIGNED = 1
) (
    input  logic                 clk,
    input  logic                 clear,
    systolic_mm_array_if.slave   bus
);
    localparam int RW  = $clog2(N);
    localparam int BW  = $clog2(K+1);
    localparam int DCW = $clog2(2*N);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, OUT} state_e;

    state_e           state_q, state_d;
    logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
    logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
    logic [RW-1:0]    row_q, row_d;
    logic             accept, zero_acc, out_fire, unused_edge;

    logic [N-1:0][DW-1:0]         inj_a, inj_b, a_sk, b_sk;
    logic [N-1:0][N-1:0][DW-1:0]  a_link, b_link, a_pe, b_pe;
    logic [N-1:0][N-1:0][AW-1:0]  acc;

    assign accept   = bus.in_valid & bus.in_ready;
    assign out_fire = bus.out_valid & bus.out_ready;
    assign zero_acc = accept & (state_q == IDLE) & ~bus.acc_en;

    // Cycles without an accepted beat push zero operands (bubbles).
    always_comb begin
        inj_a = '0;
        inj_b = '0;
        for (int i = 0; i < N; i++) begin
            inj_a[i] = accept ? bus.a_col[i*DW +: DW] : '0;
            inj_b[i] = accept ? bus.b_row[i*DW +: DW] : '0;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign a_sk[i] = inj_a[i];
            assign b_sk[i] = inj_b[i];
        end else begin : g_dly
            logic [i-1:0][DW-1:0] sa_q, sa_d, sb_q, sb_d;
            always_comb begin
                sa_d    = '0;
                sb_d    = '0;
                sa_d[0] = inj_a[i];
                sb_d[0] = inj_b[i];
                for (int s = 1; s < i; s++) begin
                    sa_d[s] = sa_q[s-1];
                    sb_d[s] = sb_q[s-1];
                end
            end
            always_ff @(posedge clk) begin
                if (clear) begin
                    sa_q <= '0;
                    sb_q <= '0;
                end else begin
                    sa_q <= sa_d;
                    sb_q <= sb_d;
                end
            end
            assign a_sk[i] = sa_q[i-1];
            assign b_sk[i] = sb_q[i-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (j == 0) begin : g_al
                assign a_link[i][j] = a_sk[i];
            end else begin : g_ai
                assign a_link[i][j] = a_pe[i][j-1];
            end
            if (i == 0) begin : g_bl
                assign b_link[i][j] = b_sk[j];
            end else begin : g_bi
                assign b_link[i][j] = b_pe[i-1][j];
            end
            systolic_mm_pe #(.DW(DW), .AW(AW), .SIGNED(SIGNED)) u_pe (
                .clk      (clk),
                .clear    (clear),
                .zero_acc (zero_acc),
                .a_in     (a_link[i][j]),
                .b_in     (b_link[i][j]),
                .a_q      (a_pe[i][j]),
                .b_q      (b_pe[i][j]),
                .acc_q    (acc[i][j])
            );
        end
    end

    // Operands leaving the right column / bottom row have no consumer.
    always_comb begin
        unused_edge = 1'b0;
        for (int i = 0; i < N; i++) unused_edge = unused_edge ^ (^a_pe[i][N-1]) ^ (^b_pe[N-1][i]);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            row_q       <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            row_q       <= row_d;
        end
    end

    // DRAIN lasts 2N-1 cycles: the far-corner PE consumes the last beat then.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        drain_cnt_d = drain_cnt_q;
        row_d       = row_q;
        case (state_q)
            IDLE: if (accept) begin
                beat_cnt_d = BW'(1);
                if (K == 1) begin
                    state_d     = DRAIN;
                    drain_cnt_d = DCW'(2*N-1);
                end else begin
                    state_d = FEED;
                end
            end
            FEED: if (accept) begin
                beat_cnt_d = beat_cnt_q + BW'(1);
                if (beat_cnt_q == BW'(K-1)) begin
                    state_d     = DRAIN;
                    drain_cnt_d = DCW'(2*N-1);
                end
            end
            DRAIN: begin
                drain_cnt_d = drain_cnt_q - DCW'(1);
                if (drain_cnt_q == DCW'(1)) begin
                    state_d = OUT;
                    row_d   = '0;
                end
            end
            OUT: if (out_fire) begin
                row_d = row_q + RW'(1);
                if (row_q == RW'(N-1)) begin
                    state_d = IDLE;
                    row_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready    = 1'b0;
        bus.out_valid   = 1'b0;
        bus.busy        = 1'b0;
        bus.out_row     = '0;
        bus.out_row_idx = '0;
        if (!clear) begin
            bus.in_ready = (state_q == IDLE) || (state_q == FEED);
            bus.busy     = (state_q != IDLE);
            if (state_q == OUT) begin
                bus.out_valid   = 1'b1;
                bus.out_row     = acc[row_q];
                bus.out_row_idx = row_q;
            end
        end
    end
endmodule

// File: tb/tb_systolic_mm_array.sv
// Directed-sequence bench: signed and unsigned arrays run in lockstep against a
// plain-arithmetic matrix-product model.
module tb_systolic_mm_array;
    localparam int N  = 5;
    localparam int DW = 8;
    localparam int AW = 20;
    localparam int K  = 5;
    localparam int CW = N*AW;
    typedef logic [CW-1:0] cw_t;

    logic clk = 1'b0;
    logic clear;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    systolic_mm_array_if #(.N(N), .DW(DW), .AW(AW)) ifs ();
    systolic_mm_array_if #(.N(N), .DW(DW), .AW(AW)) ifu ();

    assign ifu.in_valid  = ifs.in_valid;
    assign ifu.acc_en    = ifs.acc_en;
    assign ifu.a_col     = ifs.a_col;
    assign ifu.b_row     = ifs.b_row;
    assign ifu.out_ready = ifs.out_ready;

    systolic_mm_array #(.N(N), .DW(DW), .AW(AW), .K(K), .SIGNED(1)) dut (
        .clk(clk), .clear(clear), .bus(ifs));
    systolic_mm_array #(.N(N), .DW(DW), .AW(AW), .K(K), .SIGNED(0)) dut_u (
        .clk(clk), .clear(clear), .bus(ifu));

    logic [DW-1:0] ma [N][K];
    logic [DW-1:0] mb [K][N];
    logic [AW-1:0] exp_s [N][N];
    logic [AW-1:0] exp_u [N][N];

    task automatic chk(input string tag, input cw_t obs, input cw_t expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic rnd_in();
        ifs.a_col = (N*DW)'({$urandom(), $urandom()});
        ifs.b_row = (N*DW)'({$urandom(), $urandom()});
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K; k++)
                case (mode)
                    0:       ma[i][k] = (i == k) ? DW'(1) : DW'(0);
                    1:       ma[i][k] = 8'hFF;
                    default: ma[i][k] = DW'($urandom());
                endcase
        for (int k = 0; k < K; k++)
            for (int j = 0; j < N; j++)
                case (mode)
                    0:       mb[k][j] = DW'(10*k + j);
                    1:       mb[k][j] = 8'h02;
                    default: mb[k][j] = DW'($urandom());
                endcase
    endtask

    task automatic model_zero();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                exp_s[i][j] = '0;
                exp_u[i][j] = '0;
            end
    endtask

    task automatic model_batch(input bit acc);
        longint ss, su;
        if (!acc) model_zero();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ss = 0;
                su = 0;
                for (int k = 0; k < K; k++) begin
                    ss += longint'($signed(ma[i][k])) * longint'($signed(mb[k][j]));
                    su += longint'(ma[i][k]) * longint'(mb[k][j]);
                end
                exp_s[i][j] = exp_s[i][j] + ss[AW-1:0];
                exp_u[i][j] = exp_u[i][j] + su[AW-1:0];
            end
    endtask

    function automatic cw_t exp_row(input int r, input bit s);
        cw_t v;
        v = '0;
        for (int j = 0; j < N; j++) v[j*AW +: AW] = s ? exp_s[r][j] : exp_u[r][j];
        return v;
    endfunction

    // Called away from a clock edge; returns at the negedge after release.
    task automatic pulse_clear();
        clear = 1'b1;
        ifs.in_valid = 1'b0;
        #1;
        chk("clr_in_ready", cw_t'(ifs.in_ready), cw_t'(0));
        chk("clr_out_valid", cw_t'(ifs.out_valid), cw_t'(0));
        chk("clr_busy", cw_t'(ifs.busy), cw_t'(0));
        chk("clr_out_row", ifs.out_row, cw_t'(0));
        chk("clr_row_idx", cw_t'(ifs.out_row_idx), cw_t'(0));
        @(posedge clk); #1;
        clear = 1'b0;
        model_zero();
        @(negedge clk);
        chk("post_clr_in_ready", cw_t'(ifs.in_ready), cw_t'(1));
        chk("post_clr_busy", cw_t'(ifs.busy), cw_t'(0));
    endtask

    task automatic send_batch(input bit acc, input bit gap, input int nbeats, output int t_last);
        t_last = 0;
        @(posedge clk); #1;
        for (int k = 0; k < nbeats; k++) begin
            ifs.in_valid = 1'b1;
            ifs.acc_en   = acc;
            for (int i = 0; i < N; i++) begin
                ifs.a_col[i*DW +: DW] = ma[i][k];
                ifs.b_row[i*DW +: DW] = mb[k][i];
            end
            @(negedge clk);
            chk("in_ready_feed", cw_t'(ifs.in_ready), cw_t'(1));
            @(posedge clk); #1;
            t_last = cyc;
            if (gap && k < nbeats-1) begin
                ifs.in_valid = 1'b0;
                rnd_in();
                @(negedge clk);
                chk("in_ready_bubble", cw_t'(ifs.in_ready), cw_t'(1));
                @(posedge clk); #1;
            end
        end
        ifs.in_valid = 1'b0;
    endtask

    // Returns at the negedge where out_valid is first seen (or after the bound).
    task automatic wait_out(input bit garbage, input int t_last);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            ifs.in_valid = garbage;
            if (garbage) rnd_in();
            @(negedge clk);
            if (ifs.out_valid) seen = 1'b1;
            else begin
                chk("in_ready_drain", cw_t'(ifs.in_ready), cw_t'(0));
                @(posedge clk); #1;
                n++;
            end
        end
        chk("latency", cw_t'(seen ? cyc - t_last : -1), cw_t'(2*N-1));
    endtask

    task automatic recv(input bit garbage, input int bp_row, input int clr_row);
        for (int r = 0; r < N; r++) begin
            chk("out_valid", cw_t'(ifs.out_valid), cw_t'(1));
            chk("row_idx", cw_t'(ifs.out_row_idx), cw_t'(r));
            chk("row_signed", ifs.out_row, exp_row(r, 1'b1));
            chk("row_unsigned", ifu.out_row, exp_row(r, 1'b0));
            if (r == clr_row) begin
                pulse_clear();
                return;
            end
            if (r == bp_row) begin
                ifs.out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk("bp_idx", cw_t'(ifs.out_row_idx), cw_t'(r));
                    chk("bp_row", ifs.out_row, exp_row(r, 1'b1));
                end
                ifs.out_ready = 1'b1;
            end
            if (r == N-1) ifs.in_valid = 1'b0;
            else if (garbage) rnd_in();
            @(negedge clk);
        end
        chk("done_out_valid", cw_t'(ifs.out_valid), cw_t'(0));
        chk("done_busy", cw_t'(ifs.busy), cw_t'(0));
        chk("done_in_ready", cw_t'(ifs.in_ready), cw_t'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        clear = 1'b1;
        ifs.in_valid  = 1'b0;
        ifs.acc_en    = 1'b0;
        ifs.out_ready = 1'b1;
        ifs.a_col     = '0;
        ifs.b_row     = '0;
        model_zero();
        @(posedge clk); #1;
        pulse_clear();

        // identity, continuous valid
        fill(0);
        send_batch(1'b0, 1'b0, K, t); model_batch(1'b0);
        wait_out(1'b0, t); recv(1'b0, -1, -1);

        // all -1 times all 2: signed vs unsigned interpretation
        fill(1);
        send_batch(1'b0, 1'b0, K, t); model_batch(1'b0);
        wait_out(1'b0, t);
        chk("ff02_signed", cw_t'(ifs.out_row[AW-1:0]), cw_t'(20'hFFFF6));
        chk("ff02_unsigned", cw_t'(ifu.out_row[AW-1:0]), cw_t'(20'h009F6));
        recv(1'b0, -1, -1);

        // bubbles, then the same batch accumulated on top
        fill(0);
        send_batch(1'b0, 1'b1, K, t); model_batch(1'b0);
        wait_out(1'b0, t); recv(1'b0, -1, -1);
        send_batch(1'b1, 1'b0, K, t); model_batch(1'b1);
        wait_out(1'b0, t);
        chk("accum_doubled", cw_t'(ifs.out_row[AW +: AW]), cw_t'(2));
        recv(1'b0, -1, -1);

        // backpressure at row 2
        fill(2);
        send_batch(1'b0, 1'b0, K, t); model_batch(1'b0);
        wait_out(1'b0, t); recv(1'b0, 2, -1);

        // clear during FEED, then accumulate onto what must be zero
        fill(2);
        send_batch(1'b0, 1'b0, 3, t);
        pulse_clear();
        fill(0);
        send_batch(1'b1, 1'b0, K, t); model_batch(1'b1);
        wait_out(1'b0, t); recv(1'b0, -1, -1);

        // clear during OUT at row 1
        send_batch(1'b0, 1'b0, K, t); model_batch(1'b0);
        wait_out(1'b0, t); recv(1'b0, -1, 1);
        send_batch(1'b1, 1'b0, K, t); model_batch(1'b1);
        wait_out(1'b0, t); recv(1'b0, -1, -1);

        // garbage offered while not ready
        fill(2);
        send_batch(1'b0, 1'b0, K, t); model_batch(1'b0);
        wait_out(1'b1, t); recv(1'b1, -1, -1);
        fill(2);
        send_batch(1'b1, 1'b1, K, t); model_batch(1'b1);
        wait_out(1'b1, t); recv(1'b1, 3, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
